// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin grant sequencer.
// The index width is tied to the 4-to-16 decoder that sits downstream.
package rr_arb_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority find-first: returns the first set request at or above ptr,
// wrapping from the top index back to 0.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             ptr,
  output idx_t             winner,
  output logic             any
);

  idx_t cand;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      // The index arithmetic is modulo N_REQ, so the search wraps naturally.
      cand = ptr + idx_t'(i);
      if (!any && req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter issuing one registered grant (index + enable) at a time,
// with release, withdrawal and hold-timeout exits and a guaranteed dead cycle.
module rr_grant_sequencer
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 255,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output idx_t             grant_idx,
  output logic             grant_en,
  output logic             grant_timeout,
  output logic             busy
);

  localparam logic [HOLD_W-1:0] HoldLast =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  idx_t              ptr_q, ptr_d;
  idx_t              idx_q, idx_d;
  logic              en_q, en_d;
  logic              to_q, to_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  idx_t winner;
  logic any;
  logic hold_expired;
  logic exit_grant;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  assign hold_expired = (MAX_HOLD != 0) && (hold_q == HoldLast);
  assign exit_grant   = done || !req[idx_q] || hold_expired;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    en_d    = en_q;
    to_d    = 1'b0;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        en_d = 1'b0;
        if (arb_en && any) begin
          idx_d   = winner;
          en_d    = 1'b1;
          hold_d  = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (exit_grant) begin
          en_d    = 1'b0;
          state_d = StIdle;
          ptr_d   = idx_q + idx_t'(1);
          // Timeout only flags when neither release nor withdrawal explains the exit.
          to_d    = !done && req[idx_q];
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      to_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      to_q    <= to_d;
      hold_q  <= hold_d;
    end
  end

  assign grant_idx     = idx_q;
  assign grant_en      = en_q;
  assign grant_timeout = to_q;
  assign busy          = (state_q == StGrant);

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench for rr_grant_sequencer with a short hold limit (MAX_HOLD = 4)
// so the timeout path is reachable in a few cycles.
module tb_rr_grant_sequencer;

  logic        clk;
  logic        rst_n;
  logic        arb_en;
  logic [15:0] req;
  logic        done;
  logic [3:0]  grant_idx;
  logic        grant_en;
  logic        grant_timeout;
  logic        busy;

  int n_checks;
  int n_fail;

  rr_grant_sequencer #(
    .MAX_HOLD (4),
    .HOLD_W   (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arb_en        (arb_en),
    .req           (req),
    .done          (done),
    .grant_idx     (grant_idx),
    .grant_en      (grant_en),
    .grant_timeout (grant_timeout),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; pulses reset between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  int exp4[4] = '{0, 15, 0, 15};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    arb_en   = 1'b0;
    req      = '0;
    done     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_idx", int'(grant_idx), 0);
    check_eq("rst_en", int'(grant_en), 0);
    check_eq("rst_to", int'(grant_timeout), 0);
    check_eq("rst_busy", int'(busy), 0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Test 1: grant 7, release (ptr -> 8), regrant 7, reset mid-grant.
    arb_en = 1'b1;
    req    = 16'h0080;
    cyc();
    check_eq("t1_en", int'(grant_en), 1);
    check_eq("t1_idx", int'(grant_idx), 7);
    check_eq("t1_busy", int'(busy), 1);
    done = 1'b1;
    cyc();
    check_eq("t1_rel_en", int'(grant_en), 0);
    check_eq("t1_rel_to", int'(grant_timeout), 0);
    done = 1'b0;
    cyc();
    check_eq("t1_regrant_en", int'(grant_en), 1);
    check_eq("t1_regrant_idx", int'(grant_idx), 7);
    cyc();
    check_eq("t1_hold_en", int'(grant_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_async_en", int'(grant_en), 0);
    check_eq("t1_async_busy", int'(busy), 0);
    check_eq("t1_async_to", int'(grant_timeout), 0);
    check_eq("t1_async_idx", int'(grant_idx), 0);
    #3 rst_n = 1'b1;
    req = 16'h0201;  // ptr 0 picks 0; a stale ptr of 8 would pick 9
    cyc();
    check_eq("t1_post_en", int'(grant_en), 1);
    check_eq("t1_post_idx", int'(grant_idx), 0);
    done = 1'b1;
    cyc();
    done = 1'b0;
    req  = '0;
    cyc();

    // Test 2: single requester 5, done during the 3rd grant cycle.
    req = 16'h0020;
    cyc();
    check_eq("t2_c1_en", int'(grant_en), 1);
    check_eq("t2_c1_idx", int'(grant_idx), 5);
    cyc();
    check_eq("t2_c2_en", int'(grant_en), 1);
    cyc();
    check_eq("t2_c3_en", int'(grant_en), 1);
    check_eq("t2_c3_idx", int'(grant_idx), 5);
    done = 1'b1;
    cyc();
    check_eq("t2_gap_en", int'(grant_en), 0);
    check_eq("t2_gap_to", int'(grant_timeout), 0);
    check_eq("t2_gap_idx", int'(grant_idx), 5);
    done = 1'b0;
    cyc();
    check_eq("t2_regrant_en", int'(grant_en), 1);
    check_eq("t2_regrant_idx", int'(grant_idx), 5);
    req = '0;
    cyc();
    check_eq("t2_wd_en", int'(grant_en), 0);
    check_eq("t2_wd_to", int'(grant_timeout), 0);
    cyc();

    // Test 3: all requesting, prompt release -> 0..15,0 with gaps.
    req  = 16'hFFFF;
    done = 1'b1;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      cyc();
      check_eq("t3_en", int'(grant_en), 1);
      check_eq("t3_idx", int'(grant_idx), k % 16);
      cyc();
      check_eq("t3_gap_en", int'(grant_en), 0);
      check_eq("t3_gap_to", int'(grant_timeout), 0);
    end

    // Test 4: wrap between 0 and 15.
    req = 16'h8001;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc();
      check_eq("t4_en", int'(grant_en), 1);
      check_eq("t4_idx", int'(grant_idx), exp4[k]);
      cyc();
      check_eq("t4_gap_en", int'(grant_en), 0);
    end

    // Test 5: timeout after 4 cycles, then done coinciding with timeout.
    done = 1'b0;
    req  = 16'h0108;
    do_reset();
    cyc();
    check_eq("t5_idx", int'(grant_idx), 3);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) cyc();
      check_eq("t5_hold_en", int'(grant_en), 1);
      check_eq("t5_hold_to", int'(grant_timeout), 0);
    end
    cyc();
    check_eq("t5_to_en", int'(grant_en), 0);
    check_eq("t5_to_pulse", int'(grant_timeout), 1);
    cyc();
    check_eq("t5_next_en", int'(grant_en), 1);
    check_eq("t5_next_idx", int'(grant_idx), 8);
    check_eq("t5_to_clear", int'(grant_timeout), 0);
    cyc();
    cyc();
    cyc();
    check_eq("t5_c4_en", int'(grant_en), 1);
    done = 1'b1;
    cyc();
    check_eq("t5_done_to_en", int'(grant_en), 0);
    check_eq("t5_done_to_pulse", int'(grant_timeout), 0);
    done = 1'b0;
    req  = '0;
    cyc();

    // Test 6: withdrawal of 9, then arb_en gating; ptr is 9 here.
    req = 16'h0200;
    cyc();
    check_eq("t6_en", int'(grant_en), 1);
    check_eq("t6_idx", int'(grant_idx), 9);
    cyc();
    req = '0;
    cyc();
    check_eq("t6_wd_en", int'(grant_en), 0);
    check_eq("t6_wd_to", int'(grant_timeout), 0);
    arb_en = 1'b0;
    req    = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_eq("t6_gated_en", int'(grant_en), 0);
      check_eq("t6_gated_busy", int'(busy), 0);
    end
    arb_en = 1'b1;
    cyc();
    check_eq("t6_resume_en", int'(grant_en), 1);
    check_eq("t6_resume_idx", int'(grant_idx), 10);
    done = 1'b1;
    cyc();
    check_eq("t6_end_en", int'(grant_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
